// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the frame controller: FSM encoding, register map,
// register bit positions, mode codes and small helper functions.
package proc_ctrl_pkg;

  // Controller states; the encoding is visible to software in STATUS[6:4]
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ctrlState_e;

  // Pixel processor operating modes; code 3 behaves like a pass-through frame
  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_INVERT = 2'd1,
    MODE_CONV   = 2'd2,
    MODE_RSVD   = 2'd3
  } procMode_e;

  // Register byte offsets
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_MODE   = 8'h04;
  localparam logic [7:0] ADDR_KERN0  = 8'h08;
  localparam logic [7:0] ADDR_KERN1  = 8'h0C;
  localparam logic [7:0] ADDR_KERN2  = 8'h10;
  localparam logic [7:0] ADDR_STATUS = 8'h14;
  localparam logic [7:0] ADDR_INCNT  = 8'h18;
  localparam logic [7:0] ADDR_OUTCNT = 8'h1C;

  // CTRL bit positions
  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_IRQEN_BIT = 2;

  // STATUS bit positions
  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_ERR_BIT   = 2;
  localparam int STAT_STATE_LSB = 4;

  // Pixel counter width
  localparam int CNT_W = 21;

  // Kernel reset value: every coefficient byte is 1
  localparam logic [71:0] KERNEL_RESET = {9{8'h01}};

  // Number of output pixels a frame is expected to produce in a given mode.
  // Convolution loses its warm-up pixels, clamped at zero.
  function automatic logic [CNT_W-1:0] expectedOutCount(input logic [1:0] mode,
                                                        input int framePixels,
                                                        input int warmup);
    int count;
    if (mode == MODE_CONV) begin
      count = (framePixels > warmup) ? (framePixels - warmup) : 0;
    end else begin
      count = framePixels;
    end
    return CNT_W'(count);
  endfunction

  // Merge a bus write into an existing word, byte lane by byte lane
  function automatic logic [31:0] applyStrobes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  strb);
    logic [31:0] result;
    result = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        result[8*b +: 8] = newWord[8*b +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/proc_ctrl_if.sv
// Memory-mapped register bus between the CPU and the frame controller.
interface proc_ctrl_if;

  logic        iomem_valid;
  logic        iomem_ready;
  logic [7:0]  iomem_addr;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  // CPU side issues requests and receives the acknowledge and read data
  modport master (
    output iomem_valid,
    output iomem_addr,
    output iomem_wstrb,
    output iomem_wdata,
    input  iomem_ready,
    input  iomem_rdata
  );

  // Controller side answers requests
  modport slave (
    input  iomem_valid,
    input  iomem_addr,
    input  iomem_wstrb,
    input  iomem_wdata,
    output iomem_ready,
    output iomem_rdata
  );

endinterface

// File: rtl/proc_ctrl_regs.sv
// Register file of the frame controller: bus decode and acknowledge, the
// shadow MODE/kernel registers, IRQ enable, sticky DONE/ERR flags and the
// registered interrupt line.
module proc_ctrl_regs
  import proc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  proc_ctrl_if.slave       bus,
  input  logic             busy_i,
  input  logic [2:0]       state_i,
  input  logic [CNT_W-1:0] inCount_i,
  input  logic [CNT_W-1:0] outCount_i,
  input  logic             doneSet_i,
  input  logic             errSet_i,
  output logic             startPulse_o,
  output logic             abortPulse_o,
  output logic [1:0]       shadowMode_o,
  output logic [71:0]      shadowKernel_o,
  output logic             irq_o
);

  logic        ready_q;
  logic [31:0] rdata_q;
  logic        irqEn_q, irqEn_d;
  logic [1:0]  mode_q, mode_d;
  logic [71:0] kernel_q, kernel_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        irq_q;
  logic        wrEn;
  logic        accept;
  logic [31:0] readData;

  // Decode writes; hardware flag sets are applied last so they beat a clear
  always_comb begin
    accept       = bus.iomem_valid && !ready_q;
    wrEn         = bus.iomem_valid && ready_q && (bus.iomem_wstrb != 4'b0000);
    irqEn_d      = irqEn_q;
    mode_d       = mode_q;
    kernel_d     = kernel_q;
    done_d       = done_q;
    err_d        = err_q;
    startPulse_o = 1'b0;
    abortPulse_o = 1'b0;
    if (wrEn) begin
      case (bus.iomem_addr)
        ADDR_CTRL: begin
          if (bus.iomem_wstrb[0]) begin
            startPulse_o = bus.iomem_wdata[CTRL_START_BIT];
            abortPulse_o = bus.iomem_wdata[CTRL_ABORT_BIT];
            irqEn_d      = bus.iomem_wdata[CTRL_IRQEN_BIT];
          end
        end
        ADDR_MODE: begin
          if (bus.iomem_wstrb[0]) begin
            mode_d = bus.iomem_wdata[1:0];
          end
        end
        ADDR_KERN0: kernel_d[31:0]  = applyStrobes(kernel_q[31:0], bus.iomem_wdata, bus.iomem_wstrb);
        ADDR_KERN1: kernel_d[63:32] = applyStrobes(kernel_q[63:32], bus.iomem_wdata, bus.iomem_wstrb);
        ADDR_KERN2: begin
          if (bus.iomem_wstrb[0]) begin
            kernel_d[71:64] = bus.iomem_wdata[7:0];
          end
        end
        ADDR_STATUS: begin
          if (bus.iomem_wstrb[0]) begin
            if (bus.iomem_wdata[STAT_DONE_BIT]) done_d = 1'b0;
            if (bus.iomem_wdata[STAT_ERR_BIT])  err_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end
    if (doneSet_i) done_d = 1'b1;
    if (errSet_i)  err_d  = 1'b1;
  end

  // Read multiplexer; unmapped offsets read as zero
  always_comb begin
    readData = '0;
    case (bus.iomem_addr)
      ADDR_CTRL:   readData[CTRL_IRQEN_BIT] = irqEn_q;
      ADDR_MODE:   readData[1:0] = mode_q;
      ADDR_KERN0:  readData = kernel_q[31:0];
      ADDR_KERN1:  readData = kernel_q[63:32];
      ADDR_KERN2:  readData[7:0] = kernel_q[71:64];
      ADDR_STATUS: begin
        readData[STAT_BUSY_BIT]          = busy_i;
        readData[STAT_DONE_BIT]          = done_q;
        readData[STAT_ERR_BIT]           = err_q;
        readData[STAT_STATE_LSB +: 3]    = state_i;
      end
      ADDR_INCNT:  readData[CNT_W-1:0] = inCount_i;
      ADDR_OUTCNT: readData[CNT_W-1:0] = outCount_i;
      default: ;
    endcase
  end

  // One-cycle acknowledge with read data, register state and interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q  <= 1'b0;
      rdata_q  <= '0;
      irqEn_q  <= 1'b0;
      mode_q   <= 2'b00;
      kernel_q <= KERNEL_RESET;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      ready_q  <= accept;
      rdata_q  <= accept ? readData : 32'h0;
      irqEn_q  <= irqEn_d;
      mode_q   <= mode_d;
      kernel_q <= kernel_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_q    <= irqEn_q && (done_q || err_q);
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign shadowMode_o    = mode_q;
  assign shadowKernel_o  = kernel_q;
  assign irq_o           = irq_q;

endmodule

// File: rtl/proc_ctrl.sv
// Frame controller: sequences one frame of pixels from the input FIFO into
// the pixel processor, counts pixels in and out, and reports completion,
// stalls and aborts through the register block.
module proc_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int FRAME_PIXELS = 1024,
  parameter int WARMUP       = 2051,
  parameter int TIMEOUT      = 4096,
  parameter int DRAIN_IDLE   = 16
) (
  input  logic        clk,
  input  logic        rst,
  proc_ctrl_if.slave  bus,
  input  logic        src_valid,
  output logic        src_rd,
  output logic        proc_valid,
  input  logic        proc_ready,
  output logic [1:0]  proc_mode,
  output logic [71:0] proc_kernel,
  input  logic        out_valid,
  output logic        irq
);

  localparam int STALL_W = $clog2(TIMEOUT + 1);
  localparam int IDLE_W  = $clog2(DRAIN_IDLE + 1);
  localparam logic [CNT_W-1:0]   FRAME_CNT  = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0]   LAST_CNT   = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT - 1);
  localparam logic [IDLE_W-1:0]  IDLE_LAST  = IDLE_W'(DRAIN_IDLE - 1);

  ctrlState_e         state_q, state_d;
  logic               armCnt_q, armCnt_d;
  logic [CNT_W-1:0]   inCount_q, inCount_d;
  logic [CNT_W-1:0]   outCount_q, outCount_d;
  logic [STALL_W-1:0] stallCnt_q, stallCnt_d;
  logic [IDLE_W-1:0]  idleCnt_q, idleCnt_d;
  logic [1:0]         activeMode_q, activeMode_d;
  logic [71:0]        activeKernel_q, activeKernel_d;
  logic [CNT_W-1:0]   expCount;
  logic               xfer, busy, doneSet, errSet;
  logic               lastPixel, stallExpired, drainComplete;
  logic               startPulse, abortPulse;
  logic [1:0]         shadowMode;
  logic [71:0]        shadowKernel;

  proc_ctrl_regs u_regs (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .busy_i         (busy),
    .state_i        (state_q),
    .inCount_i      (inCount_q),
    .outCount_i     (outCount_q),
    .doneSet_i      (doneSet),
    .errSet_i       (errSet),
    .startPulse_o   (startPulse),
    .abortPulse_o   (abortPulse),
    .shadowMode_o   (shadowMode),
    .shadowKernel_o (shadowKernel),
    .irq_o          (irq)
  );

  assign expCount = expectedOutCount(activeMode_q, FRAME_PIXELS, WARMUP);

  // Frame progress conditions that steer the FSM. A mode that expects no
  // output pixels at all can only finish through the drain idle limit.
  always_comb begin
    xfer          = (state_q == ST_RUN) && src_valid && proc_ready && (inCount_q < FRAME_CNT);
    lastPixel     = (xfer && (inCount_q == LAST_CNT)) || (inCount_q >= FRAME_CNT);
    stallExpired  = !xfer && (stallCnt_q == STALL_LAST);
    drainComplete = ((expCount != '0) && (outCount_q == expCount)) ||
                    (!out_valid && (idleCnt_q == IDLE_LAST));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; an abort overrides every other transition
  always_comb begin
    state_d = state_q;
    if (abortPulse && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (startPulse) state_d = ST_ARM;
        ST_ARM:   if (armCnt_q) state_d = ST_RUN;
        ST_RUN: begin
          if (stallExpired)   state_d = ST_IDLE;
          else if (lastPixel) state_d = ST_DRAIN;
        end
        ST_DRAIN: if (drainComplete) state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: pixel handshake, busy and the flag-set strobes
  always_comb begin
    proc_valid = xfer;
    src_rd     = xfer;
    busy       = (state_q != ST_IDLE);
    doneSet    = (state_q == ST_DONE) && !abortPulse;
    errSet     = (state_q == ST_RUN) && stallExpired && !abortPulse;
  end

  // Counters and the active configuration latched at frame start
  always_comb begin
    inCount_d      = inCount_q;
    outCount_d     = outCount_q;
    activeMode_d   = activeMode_q;
    activeKernel_d = activeKernel_q;
    if ((state_q == ST_IDLE) && startPulse) begin
      inCount_d      = '0;
      outCount_d     = '0;
      activeMode_d   = shadowMode;
      activeKernel_d = shadowKernel;
    end
    if (xfer) begin
      inCount_d = inCount_q + CNT_W'(1);
    end
    if (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && out_valid && (outCount_q != '1)) begin
      outCount_d = outCount_q + CNT_W'(1);
    end
    stallCnt_d = ((state_q == ST_RUN) && !xfer) ? stallCnt_q + STALL_W'(1) : '0;
    idleCnt_d  = ((state_q == ST_DRAIN) && !out_valid) ? idleCnt_q + IDLE_W'(1) : '0;
    armCnt_d   = (state_q == ST_ARM) ? !armCnt_q : 1'b0;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      armCnt_q       <= 1'b0;
      inCount_q      <= '0;
      outCount_q     <= '0;
      stallCnt_q     <= '0;
      idleCnt_q      <= '0;
      activeMode_q   <= 2'b00;
      activeKernel_q <= KERNEL_RESET;
    end else begin
      armCnt_q       <= armCnt_d;
      inCount_q      <= inCount_d;
      outCount_q     <= outCount_d;
      stallCnt_q     <= stallCnt_d;
      idleCnt_q      <= idleCnt_d;
      activeMode_q   <= activeMode_d;
      activeKernel_q <= activeKernel_d;
    end
  end

  assign proc_mode   = activeMode_q;
  assign proc_kernel = activeKernel_q;

endmodule

// File: tb/tb_proc_ctrl.sv
// Directed testbench for the frame controller: register access, bypass,
// convolution, backpressure, stall, abort/shadow and mid-frame reset.
module tb_proc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        src_valid, src_rd, proc_valid, proc_ready, out_valid, irq;
  logic [1:0]  proc_mode;
  logic [71:0] proc_kernel;

  int cmpCount = 0;
  int errCount = 0;

  localparam logic [71:0] KRESET = 72'h010101010101010101;

  proc_ctrl_if bus ();

  proc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .src_valid   (src_valid),
    .src_rd      (src_rd),
    .proc_valid  (proc_valid),
    .proc_ready  (proc_ready),
    .proc_mode   (proc_mode),
    .proc_kernel (proc_kernel),
    .out_valid   (out_valid),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Safety net so a wedged run still ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    cmpCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One bus transaction; returns after the commit edge with valid dropped
  task automatic busAccess(input logic [7:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, output logic [31:0] rdata);
    bit gotReady;
    gotReady = 1'b0;
    rdata    = '0;
    @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = addr;
    bus.iomem_wstrb = strb;
    bus.iomem_wdata = wdata;
    for (int i = 0; i < 4 && !gotReady; i++) begin
      @(negedge clk);
      if (bus.iomem_ready) begin
        gotReady = 1'b1;
        rdata    = bus.iomem_rdata;
      end
    end
    checkOutput("bus_ready", {71'b0, gotReady}, 72'd1);
    @(negedge clk);
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'b0000;
  endtask

  task automatic busWrite(input logic [7:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    logic [31:0] dummy;
    busAccess(addr, strb, wdata, dummy);
  endtask

  task automatic busRead(input logic [7:0] addr, output logic [31:0] rdata);
    busAccess(addr, 4'b0000, 32'h0, rdata);
  endtask

  // Run the pixel side for up to maxCycles cycles, echoing proc_valid onto
  // out_valid one cycle later when echo is set; stops early at stopAt pulses.
  task automatic applyStimulus(input bit echo, input bit toggleReady, input int maxCycles,
                               input int stopAt, output int pulses, output int badRd,
                               output int lastPulse, output int firstIrq);
    bit prevPv, pv;
    prevPv    = 1'b0;
    pulses    = 0;
    badRd     = 0;
    lastPulse = -1;
    firstIrq  = -1;
    for (int c = 0; c < maxCycles; c++) begin
      @(negedge clk);
      if (toggleReady) proc_ready = ~proc_ready;
      out_valid = echo & prevPv;
      #1;
      pv = proc_valid;
      if (pv) begin
        pulses++;
        lastPulse = c;
      end
      if (src_rd && !proc_ready) badRd++;
      if (src_rd !== proc_valid) badRd++;
      if (irq && (firstIrq < 0)) firstIrq = c;
      prevPv = pv;
      if ((stopAt > 0) && (pulses == stopAt)) break;
    end
    out_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int pulses, badRd, lastPulse, firstIrq;

    rst             = 1'b1;
    src_valid       = 1'b1;
    proc_ready      = 1'b1;
    out_valid       = 1'b0;
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = 8'h00;
    bus.iomem_wstrb = 4'b0000;
    bus.iomem_wdata = 32'h0;

    // Reset values
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", {71'b0, bus.iomem_ready}, 72'd0);
    checkOutput("rst_rdata", {40'b0, bus.iomem_rdata}, 72'd0);
    checkOutput("rst_irq", {71'b0, irq}, 72'd0);
    checkOutput("rst_proc_valid", {71'b0, proc_valid}, 72'd0);
    checkOutput("rst_src_rd", {71'b0, src_rd}, 72'd0);
    checkOutput("rst_proc_mode", {70'b0, proc_mode}, 72'd0);
    checkOutput("rst_kernel", proc_kernel, KRESET);
    rst = 1'b0;

    busRead(8'h14, rd);
    checkOutput("status_idle", {40'b0, rd}, 72'h0);
    busRead(8'h08, rd);
    checkOutput("kern0_reset", {40'b0, rd}, 72'h01010101);
    busWrite(8'h40, 32'hFFFFFFFF, 4'hF);
    busRead(8'h40, rd);
    checkOutput("unmapped_read", {40'b0, rd}, 72'h0);
    busRead(8'h04, rd);
    checkOutput("mode_after_unmapped_wr", {40'b0, rd}, 72'h0);

    // Byte-strobed shadow write does not touch the active kernel
    busWrite(8'h08, 32'hAABBCCDD, 4'b0101);
    busRead(8'h08, rd);
    checkOutput("kern0_strobe", {40'b0, rd}, 72'h01BB01DD);
    checkOutput("kernel_shadow_only", proc_kernel, KRESET);

    // Bypass frame with interrupt enabled
    busWrite(8'h04, 32'h0, 4'hF);
    busWrite(8'h00, 32'h5, 4'hF);
    checkOutput("bypass_kernel", proc_kernel, 72'h010101010101BB01DD);
    applyStimulus(1'b1, 1'b0, 1100, 0, pulses, badRd, lastPulse, firstIrq);
    checkOutput("bypass_pulses", 72'(pulses), 72'd1024);
    checkOutput("bypass_irq", {71'b0, irq}, 72'd1);
    busRead(8'h1C, rd);
    checkOutput("bypass_outcount", {40'b0, rd}, 72'd1024);
    busRead(8'h14, rd);
    checkOutput("bypass_status", {40'b0, rd}, 72'h2);
    busWrite(8'h14, 32'h6, 4'hF);
    busRead(8'h14, rd);
    checkOutput("status_w1c", {40'b0, rd}, 72'h0);

    // Convolution frame: no outputs, completes on the drain idle limit
    busWrite(8'h04, 32'h2, 4'hF);
    busWrite(8'h00, 32'h5, 4'hF);
    checkOutput("conv_mode", {70'b0, proc_mode}, 72'd2);
    applyStimulus(1'b0, 1'b0, 1100, 0, pulses, badRd, lastPulse, firstIrq);
    checkOutput("conv_pulses", 72'(pulses), 72'd1024);
    checkOutput("conv_irq_latency", 72'(firstIrq - lastPulse), 72'd19);
    busRead(8'h18, rd);
    checkOutput("conv_incount", {40'b0, rd}, 72'd1024);
    busRead(8'h1C, rd);
    checkOutput("conv_outcount", {40'b0, rd}, 72'd0);
    busRead(8'h14, rd);
    checkOutput("conv_status", {40'b0, rd}, 72'h2);
    busWrite(8'h14, 32'h6, 4'hF);

    // Backpressure: proc_ready toggles every cycle
    busWrite(8'h04, 32'h0, 4'hF);
    busWrite(8'h00, 32'h5, 4'hF);
    applyStimulus(1'b1, 1'b1, 2300, 0, pulses, badRd, lastPulse, firstIrq);
    proc_ready = 1'b1;
    checkOutput("bp_bad_src_rd", 72'(badRd), 72'd0);
    checkOutput("bp_pulses", 72'(pulses), 72'd1024);
    busRead(8'h18, rd);
    checkOutput("bp_incount", {40'b0, rd}, 72'd1024);
    busRead(8'h14, rd);
    checkOutput("bp_status", {40'b0, rd}, 72'h2);
    busWrite(8'h14, 32'h6, 4'hF);

    // Stall: no source data in RUN
    src_valid = 1'b0;
    busWrite(8'h00, 32'h5, 4'hF);
    repeat (4000) @(negedge clk);
    busRead(8'h14, rd);
    checkOutput("stall_still_run", {40'b0, rd}, 72'h21);
    repeat (200) @(negedge clk);
    busRead(8'h14, rd);
    checkOutput("stall_err", {40'b0, rd}, 72'h4);
    checkOutput("stall_irq", {71'b0, irq}, 72'd1);
    busWrite(8'h14, 32'h6, 4'hF);
    src_valid = 1'b1;

    // Abort and shadow behaviour
    busWrite(8'h10, 32'h5A, 4'hF);
    busWrite(8'h00, 32'h1, 4'hF);
    checkOutput("abort_k8", {64'b0, proc_kernel[71:64]}, 72'h5A);
    applyStimulus(1'b1, 1'b0, 100, 0, pulses, badRd, lastPulse, firstIrq);
    checkOutput("arm_two_cycles", 72'(pulses), 72'd99);
    busWrite(8'h04, 32'h1, 4'hF);
    checkOutput("mode_shadow_busy", {70'b0, proc_mode}, 72'd0);
    busWrite(8'h00, 32'h2, 4'hF);
    checkOutput("abort_proc_valid", {71'b0, proc_valid}, 72'd0);
    busRead(8'h14, rd);
    checkOutput("abort_status", {40'b0, rd}, 72'h0);
    busWrite(8'h00, 32'h1, 4'hF);
    checkOutput("restart_mode", {70'b0, proc_mode}, 72'd1);

    // Reset mid-frame at pixel 500
    applyStimulus(1'b1, 1'b0, 600, 500, pulses, badRd, lastPulse, firstIrq);
    checkOutput("pre_reset_pulses", 72'(pulses), 72'd500);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_proc_valid", {71'b0, proc_valid}, 72'd0);
    checkOutput("mid_rst_src_rd", {71'b0, src_rd}, 72'd0);
    checkOutput("mid_rst_ready", {71'b0, bus.iomem_ready}, 72'd0);
    checkOutput("mid_rst_rdata", {40'b0, bus.iomem_rdata}, 72'd0);
    checkOutput("mid_rst_irq", {71'b0, irq}, 72'd0);
    checkOutput("mid_rst_mode", {70'b0, proc_mode}, 72'd0);
    checkOutput("mid_rst_kernel", proc_kernel, KRESET);
    rst = 1'b0;
    busRead(8'h18, rd);
    checkOutput("mid_rst_incount", {40'b0, rd}, 72'd0);
    busRead(8'h14, rd);
    checkOutput("mid_rst_status", {40'b0, rd}, 72'h0);
    busWrite(8'h00, 32'h1, 4'hF);
    applyStimulus(1'b1, 1'b0, 1100, 0, pulses, badRd, lastPulse, firstIrq);
    checkOutput("post_rst_pulses", 72'(pulses), 72'd1024);
    busRead(8'h1C, rd);
    checkOutput("post_rst_outcount", {40'b0, rd}, 72'd1024);
    busRead(8'h14, rd);
    checkOutput("post_rst_status", {40'b0, rd}, 72'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule
